hz_generator: RTL and testbench

HZ_GENERATOR -- requirements
Module: hz_generator

---
 rtl/hz_generator.sv | 123 ++++++++++++
 tb/tb_hz_generator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hz_generator.sv
// hz_generator: programmable square-wave generator.
// A requested frequency is turned into a half-period with a 17-step restoring
// divider (CLK_HZ / (2*freq_hz)), then a period counter toggles sig_out.
// Optional macro HZ_GEN_SYNC_UPDATE_EN: when defined, a new half-period is held
// and applied at the next sig_out toggle. When undefined, it is applied at commit
// and the waveform restarts low.
// CLK_HZ must fit in 17 bits.
module hz_generator #(
  parameter int CLK_HZ = 100000
) (
  input  logic        clk_100kHz,
  input  logic        rst_n,
  input  logic [13:0] freq_hz,
  input  logic        freq_load,
  output logic        busy,
  output logic [16:0] half_period,
  output logic        sig_out
);
  localparam logic [16:0] DIVIDEND = 17'(CLK_HZ);
  localparam logic [4:0]  LAST_IT  = 5'd17;

  typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;

  state_t      state;
  logic [14:0] dsr;        // 2*freq_hz, latched at acceptance
  logic [14:0] rem;        // partial remainder, always < dsr
  logic [16:0] dvd;        // dividend bits shift out, quotient bits shift in
  logic [16:0] quot;       // clamped result awaiting commit
  logic [4:0]  iter;
  logic        stop_pend;  // freq_hz=0 accepted, applied on the following edge
  logic [16:0] cnt;

  logic [15:0] trial;
  logic        ge;
  logic        at_toggle;
  logic        apply_now;

  assign trial     = {rem, dvd[16]};
  assign ge        = (trial >= {1'b0, dsr});
  assign at_toggle = (half_period != 17'd0) && (cnt == half_period - 17'd1);

`ifdef HZ_GEN_SYNC_UPDATE_EN
  // Hold the new value until the waveform is at a half-cycle boundary,
  // or take it at once when the output is stopped.
  assign apply_now = (state == COMMIT) && ((half_period == 17'd0) || at_toggle);
`else
  assign apply_now = (state == COMMIT);
`endif

  // Control FSM, iterative divider and the half_period/busy registers.
  always_ff @(posedge clk_100kHz) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      half_period <= '0;
      stop_pend   <= 1'b0;
      dsr         <= '0;
      rem         <= '0;
      dvd         <= '0;
      quot        <= '0;
      iter        <= '0;
    end else begin
      stop_pend <= 1'b0;
      busy      <= (state == DIV) || ((state == COMMIT) && !apply_now);
      if (stop_pend) half_period <= '0;
      case (state)
        IDLE: begin
          if (freq_load) begin
            if (freq_hz == 14'd0) begin
              stop_pend <= 1'b1;
            end else begin
              dsr   <= {freq_hz, 1'b0};
              rem   <= '0;
              dvd   <= DIVIDEND;
              iter  <= '0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (iter == LAST_IT) begin
            // A zero quotient only happens with a small CLK_HZ; never stop the output by accident.
            quot  <= (dvd == 17'd0) ? 17'd1 : dvd;
            state <= COMMIT;
          end else begin
            rem  <= ge ? 15'(trial - {1'b0, dsr}) : trial[14:0];
            dvd  <= {dvd[15:0], ge};
            iter <= iter + 5'd1;
          end
        end
        COMMIT: begin
          if (apply_now) begin
            half_period <= quot;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Period counter: toggle sig_out every half_period cycles, idle low when stopped.
  always_ff @(posedge clk_100kHz) begin
    if (!rst_n) begin
      cnt     <= '0;
      sig_out <= 1'b0;
    end else if (stop_pend || (half_period == 17'd0)) begin
      cnt     <= '0;
      sig_out <= 1'b0;
`ifndef HZ_GEN_SYNC_UPDATE_EN
    end else if (apply_now) begin
      cnt     <= '0;
      sig_out <= 1'b0;
`endif
    end else if (at_toggle) begin
      cnt     <= '0;
      sig_out <= ~sig_out;
    end else begin
      cnt <= cnt + 17'd1;
    end
  end

endmodule

// File: tb/tb_hz_generator.sv
// tb_hz_generator: directed corner cases, a divider vector table and random
// load traffic, all checked every cycle against an event-level reference model.
module tb_hz_generator;
  localparam int CLK_HZ = 100000;

  logic        clk_100kHz = 1'b0;
  logic        rst_n;
  logic [13:0] freq_hz;
  logic        freq_load;
  logic        busy;
  logic [16:0] half_period;
  logic        sig_out;

  always #5 clk_100kHz = ~clk_100kHz;

  hz_generator #(.CLK_HZ(CLK_HZ)) dut (
    .clk_100kHz (clk_100kHz),
    .rst_n      (rst_n),
    .freq_hz    (freq_hz),
    .freq_load  (freq_load),
    .busy       (busy),
    .half_period(half_period),
    .sig_out    (sig_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: a division in flight, a pending stop, and the active
  // waveform described by (half-period, start edge, level at start).
  bit m_div     = 1'b0;
  int m_acc     = 0;
  int m_q       = 0;
  int m_stop_at = -1;
  int m_hp      = 0;
  int m_start   = 0;
  bit m_sig0    = 1'b0;
  bit m_busy    = 1'b0;

  typedef struct { int f; int hp; } vec_t;
  vec_t vecs[9];

  function automatic bit model_sig(int c);
    if (m_hp == 0) return 1'b0;
    return m_sig0 ^ bit'(((c - m_start) / m_hp) & 1);
  endfunction

  // Advance the model across clock edge number cyc using the inputs seen there.
  task automatic model_step();
    bit idle;
    if (!rst_n) begin
      m_div = 1'b0; m_stop_at = -1; m_hp = 0; m_busy = 1'b0;
      m_start = cyc; m_sig0 = 1'b0;
      return;
    end
    idle = !m_div;
    if (m_stop_at == cyc) begin
      m_hp = 0; m_stop_at = -1;
    end
    if (m_div && cyc >= m_acc + 19) begin
`ifdef HZ_GEN_SYNC_UPDATE_EN
      if (m_hp == 0) begin
        m_hp = m_q; m_start = cyc; m_sig0 = 1'b0; m_div = 1'b0;
      end else if (cyc > m_start && ((cyc - m_start) % m_hp) == 0) begin
        m_sig0 = model_sig(cyc); m_start = cyc; m_hp = m_q; m_div = 1'b0;
      end
`else
      m_hp = m_q; m_start = cyc; m_sig0 = 1'b0; m_div = 1'b0;
`endif
    end
    m_busy = m_div && (cyc > m_acc);
    if (idle && freq_load) begin
      if (freq_hz != 14'd0) begin
        m_div = 1'b1; m_acc = cyc;
        m_q = CLK_HZ / (2 * int'(freq_hz));
        if (m_q == 0) m_q = 1;
      end else begin
        m_stop_at = cyc + 1;
      end
    end
  endtask

  task automatic tick();
    bit es;
    @(posedge clk_100kHz);
    cyc++;
    model_step();
    @(negedge clk_100kHz);
    if (chk_en) begin
      es = model_sig(cyc);
      checks++;
      if (busy !== m_busy || half_period !== 17'(m_hp) || sig_out !== es) begin
        errors++;
        $display("FAIL model cyc=%0d got busy=%b hp=%0d sig=%b want busy=%b hp=%0d sig=%b",
                 cyc, busy, half_period, sig_out, m_busy, m_hp, es);
      end
    end
  endtask

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic load(int f);
    freq_hz = 14'(f); freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
  endtask

  task automatic wait_done(int max);
    int n = 0;
    tick();
    while (busy && n < max) begin tick(); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_done got busy=1 after %0d cycles want 0", max);
    end
  endtask

  task automatic count_while(bit lvl, int max, output int n);
    n = 0;
    while (sig_out == lvl && n < max) begin tick(); n++; end
  endtask

  initial begin
    int n, hi, lo, bad;
    vecs[0] = '{1000, 50};   vecs[1] = '{16383, 3};  vecs[2] = '{2000, 25};
    vecs[3] = '{500, 100};   vecs[4] = '{3, 16666};  vecs[5] = '{7, 7142};
    vecs[6] = '{12345, 4};   vecs[7] = '{4096, 12};  vecs[8] = '{8, 6250};

    rst_n = 1'b0; freq_load = 1'b0; freq_hz = '0; chk_en = 1'b1;
    repeat (3) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_hp", int'(half_period), 0);
    check("reset_sig", int'(sig_out), 0);
    rst_n = 1'b1;
    tick();

    // 1000 Hz from stopped: 18 busy cycles, 50/50 waveform
    load(1000);
    n = 0;
    repeat (25) begin tick(); if (busy) n++; end
    check("busy_cycles_1000", n, 18);
    check("hp_1000", int'(half_period), 50);
    count_while(1'b0, 300, n);
    count_while(1'b1, 300, hi);
    count_while(1'b0, 300, lo);
    check("high_len_1000", hi, 50);
    check("low_len_1000", lo, 50);

    // 1000 -> 500 issued 11 cycles into a high half-cycle
    hi = 0;
    repeat (10) begin tick(); hi++; end
    load(500); hi++;
    count_while(1'b1, 300, n); hi += n;
`ifdef HZ_GEN_SYNC_UPDATE_EN
    check("update_high_len", hi, 50);
`else
    check("update_high_len", hi, 30);
`endif
    check("update_busy", int'(busy), 0);
    check("update_hp", int'(half_period), 100);
    count_while(1'b0, 300, lo);
    check("update_low_len", lo, 100);

    // stop while running at 1000
    load(1000);
    wait_done(300);
    load(0);
    check("stop_busy", int'(busy), 0);
    tick();
    check("stop_hp", int'(half_period), 0);
    check("stop_sig", int'(sig_out), 0);
    bad = 0;
    repeat (120) begin tick(); if (sig_out || half_period != 0 || busy) bad++; end
    check("stop_hold", bad, 0);

    // second load while busy is dropped; freq_hz changes after acceptance ignored
    load(2000);
    tick(); tick();
    load(500);
    freq_hz = 14'd7;
    wait_done(300);
    check("ignore_second_hp", int'(half_period), 25);

    // reset at divider iteration 8, with a load presented during reset
    load(1000);
    repeat (7) tick();
    rst_n = 1'b0; freq_hz = 14'd1000; freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_hp", int'(half_period), 0);
    check("abort_sig", int'(sig_out), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("load_in_reset_ignored", int'(busy), 0);
    load(1000);
    wait_done(300);
    check("after_abort_hp", int'(half_period), 50);

    // divider vector table
    for (int i = 0; i < 9; i++) begin
      load(vecs[i].f);
      wait_done(60000);
      check($sformatf("table_hp_f%0d", vecs[i].f), int'(half_period), vecs[i].hp);
    end

    // slowest rate: first rise 50000 cycles after commit
    load(0); tick();
    load(1);
    wait_done(300);
    check("hp_f1", int'(half_period), 50000);
    count_while(1'b0, 50010, n);
    check("first_rise_f1", n, 50000);
    load(0); tick();

    // random traffic, including loads while busy, stops and reset pulses
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 40)) tick();
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      load(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(200, 16383)));
      freq_hz = 14'($urandom);
    end
    wait_done(60000);
    repeat (50) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
